// File: rtl/uart_receiver.sv
// 8N1 UART receive deserialiser with glitch, framing and overrun detection.
// Define UART_RX_PARITY_EN to receive an even-parity bit after D7.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_pin,
    input  logic       ack,
    output logic [7:0] data_recv,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          rdy_n;
    logic          ovr_n;
    logic          ferr_n;
    logic          sync1, rxs;
    logic          take;

    // rxd_pin is asynchronous; idle-high reset avoids a false start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd_pin;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data_recv <= 8'h00;
            rdy       <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data_recv <= data_n;
            rdy       <= rdy_n;
            overrun   <= ovr_n;
            frame_err <= ferr_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par, par_n;
    logic perr_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par        <= par_n;
            parity_err <= perr_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_recv;
        rdy_n   = rdy;
        ovr_n   = overrun;
        ferr_n  = 1'b0;
        take    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par;
        perr_n  = 1'b0;
`endif

        if (ack && rdy) begin
            rdy_n = 1'b0;
            ovr_n = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (!rxs) begin
                    cnt_n   = HALF;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rxs) begin
                    cnt_n   = FULL;
                    idx_n   = 3'd0;
                    state_n = S_DATA;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n        = FULL;
                    shift_n[idx] = rxs;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n   = FULL;
                    par_n   = rxs;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    take = rxs;
`ifdef UART_RX_PARITY_EN
                    perr_n = ^{shift, par};
                    take   = rxs && !perr_n;
`endif
                    if (!rxs) begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end else begin
                        state_n = S_IDLE;
                    end
                    // a same-edge ack frees the buffer, so the load wins
                    if (take) begin
                        if (rdy && !ack) begin
                            ovr_n = 1'b1;
                        end else begin
                            data_n = shift;
                            rdy_n  = 1'b1;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames, glitches, errors, reset.
// Build with UART_RX_PARITY_EN defined to exercise the parity frames.
module tb_uart_receiver;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + CPB;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd_pin = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data_recv;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int f0, p0;
    logic rdy_q = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .rxd_pin(rxd_pin),
        .ack(ack),
        .data_recv(data_recv),
        .rdy(rdy),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy && !rdy_q) begin
            rise_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_rdy", 1, 0);
            end else begin
                exp_b = sb.pop_front();
                check("sb_data", {24'h0, data_recv}, {24'h0, exp_b});
            end
        end
        rdy_q = rdy;
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
    end

    task automatic send_bit(input logic v);
        rxd_pin = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic bad_par);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ bad_par);
`else
        if (bad_par) $display("note: parity not built");
`endif
        send_bit(stop);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
    endtask

    initial begin
        idle(3);
        check("rst_rdy", {31'h0, rdy}, 0);
        check("rst_data", {24'h0, data_recv}, 0);
        check("rst_ferr", {31'h0, frame_err}, 0);
        check("rst_ovr", {31'h0, overrun}, 0);
        check("rst_perr", {31'h0, parity_err}, 0);
        reset = 1'b1;
        idle(4);

        // basic frame and latency
        f0 = ferr_cnt;
        rise_cyc = 0;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        check("a5_latency", rise_cyc - fall_cyc, LAT);
        check("a5_data", {24'h0, data_recv}, 32'hA5);
        check("a5_rdy", {31'h0, rdy}, 1);
        check("a5_ferr", ferr_cnt - f0, 0);
        do_ack();
        check("a5_ack_rdy", {31'h0, rdy}, 0);

        // start glitch
        rxd_pin = 1'b0;
        idle(5);
        rxd_pin = 1'b1;
        idle(3 * CPB);
        check("gl_rdy", {31'h0, rdy}, 0);
        check("gl_ferr", ferr_cnt - f0, 0);
        check("gl_ovr", {31'h0, overrun}, 0);

        // framing error then recovery
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("fe_pulse", ferr_cnt - f0, 1);
        check("fe_rdy", {31'h0, rdy}, 0);
        sb.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(4);
        check("fe_next", {24'h0, data_recv}, 32'h01);
        do_ack();

        // back-to-back overrun
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(4);
        check("ov_data", {24'h0, data_recv}, 32'h11);
        check("ov_flag", {31'h0, overrun}, 1);
        check("ov_rdy", {31'h0, rdy}, 1);
        do_ack();
        check("ov_ack_rdy", {31'h0, rdy}, 0);
        check("ov_ack_ovr", {31'h0, overrun}, 0);

        // reset in the middle of data bit 4
        rxd_pin = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        idle(CPB / 2);
        reset = 1'b0;
        rxd_pin = 1'b1;
        idle(3);
        check("mr_data", {24'h0, data_recv}, 0);
        check("mr_rdy", {31'h0, rdy}, 0);
        check("mr_ovr", {31'h0, overrun}, 0);
        check("mr_ferr", {31'h0, frame_err}, 0);
        reset = 1'b1;
        idle(2 * CPB);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(4);
        check("mr_next", {24'h0, data_recv}, 32'h5A);
        check("mr_next_rdy", {31'h0, rdy}, 1);
        do_ack();

`ifdef UART_RX_PARITY_EN
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check("pe_pulse", perr_cnt - p0, 1);
        check("pe_rdy", {31'h0, rdy}, 0);
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check("pe_ok_data", {24'h0, data_recv}, 32'h07);
        check("pe_ok_rdy", {31'h0, rdy}, 1);
        check("pe_ok_cnt", perr_cnt - p0, 1);
        do_ack();
`else
        p0 = perr_cnt;
        idle(2);
        check("perr_tied", perr_cnt - p0, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
